// File: rtl/fifo_axis_packetizer.sv
// Drains a 1-cycle-latency FIFO into fixed-length AXI4-Stream packets via a 2-entry skid buffer.
// Optional macro FIFO_AXIS_TIMEOUT_EN closes a stalled partial packet after TIMEOUT_CYCLES idle cycles.
module fifo_axis_packetizer #(
  parameter int DATA_WIDTH     = 16,
  parameter int LEN_WIDTH      = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  pkt_done,
  output logic [15:0]           pkt_count,
  output logic                  busy
);

  // Stream handshake: a beat transfers on a cycle with tvalid && tready; once tvalid is
  // raised, tvalid, tdata and tlast hold until that transfer.

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic [LEN_WIDTH-1:0]  r_len_q;
  logic                  r_pkt_done;
  logic [15:0]           r_pkt_count;

  logic                  w_pop;
  logic [LEN_WIDTH-1:0]  w_last_idx;
  logic                  w_at_last;
  logic                  w_present;
  logic                  w_short;
  logic [2:0]            w_level;
  logic [1:0]            w_wr_slot;
  logic [LEN_WIDTH-1:0]  w_beat_next;

  assign w_last_idx = r_len_q - LEN_WIDTH'(1);
  assign w_at_last  = (r_beat == w_last_idx);

`ifdef FIFO_AXIS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle_cnt;
  logic          r_short;
  logic          w_timed_out;

  assign w_timed_out = (r_idle_cnt == TW'(TIMEOUT_CYCLES));
  // r_short keeps tlast stable if a late read clears the idle counter before the handshake.
  assign w_short     = w_timed_out || r_short;
  assign w_present   = (r_occ == 2'd2) || r_inflight || w_at_last || w_short;

  always_ff @(posedge clk) begin
    if (rst || fifo_rd_en || w_pop || (r_occ == 2'd0)) begin
      r_idle_cnt <= '0;
    end else if (fifo_empty && !r_inflight && !w_timed_out) begin
      r_idle_cnt <= r_idle_cnt + TW'(1);
    end
    if (rst || w_pop) begin
      r_short <= 1'b0;
    end else if (w_timed_out) begin
      r_short <= 1'b1;
    end
  end
`else
  assign w_short   = 1'b0;
  assign w_present = 1'b1;
`endif

  assign m_axis_tvalid = (r_occ != 2'd0) && w_present;
  assign m_axis_tlast  = m_axis_tvalid && (w_at_last || w_short);
  assign m_axis_tdata  = r_buf0;
  assign w_pop         = m_axis_tvalid && m_axis_tready;

  // Occupancy after this cycle's pop and landing read; a new read is only allowed if it still fits.
  assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_rd_en = !rst && enable && !fifo_empty && (r_len_q != '0) && (w_level < 3'd2);
  assign w_wr_slot  = r_occ - {1'b0, w_pop};

  always_comb begin
    w_beat_next = r_beat;
    if (w_pop) begin
      w_beat_next = m_axis_tlast ? '0 : r_beat + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_beat      <= '0;
      r_len_q     <= '0;
      r_pkt_done  <= 1'b0;
      r_pkt_count <= 16'd0;
    end else begin
      if (w_pop) begin
        r_buf0 <= r_buf1;
      end
      if (r_inflight) begin
        if (w_wr_slot == 2'd0) begin
          r_buf0 <= fifo_dout;
        end else begin
          r_buf1 <= fifo_dout;
        end
      end
      r_occ      <= w_level[1:0];
      r_inflight <= fifo_rd_en;
      r_beat     <= w_beat_next;
      // Length is sampled between packets, including the tlast beat of a back-to-back stream.
      if ((r_beat == '0 && !w_pop) || (w_pop && m_axis_tlast)) begin
        r_len_q <= pkt_len;
      end
      r_pkt_done <= w_pop && m_axis_tlast;
      if (w_pop && m_axis_tlast) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (fifo_rd_en) begin
          w_state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_pop && m_axis_tlast && (w_level == 3'd0) && !fifo_rd_en) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign busy      = (r_state == S_STREAM);
  assign pkt_done  = r_pkt_done;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// Bench for fifo_axis_packetizer: behavioural FIFO, per-beat scoreboard and packet counter model.
module tb_fifo_axis_packetizer;

  localparam int DW = 16;
  localparam int LW = 10;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [LW-1:0] pkt_len;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          pkt_done;
  logic [15:0]   pkt_count;
  logic          busy;

  fifo_axis_packetizer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pkt_len(pkt_len),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .pkt_done(pkt_done), .pkt_count(pkt_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] fifo_q[$];
  logic [DW:0]   exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int tr_mode  = 0;
  int chg_at   = -1;
  logic [LW-1:0] chg_len = '0;
  int sc_cycle, sc_pops, first_v, first_pop, last_pop, done_seen;
  int m_beat  = 0;
  int mdl_cnt = 0;
  logic exp_done   = 1'b0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic scen_start();
    sc_cycle = 0; sc_pops = 0; first_v = -1; first_pop = -1; last_pop = -1; done_seen = 0;
  endtask

  // Pushes words into the FIFO and the expected beat stream; first packet uses len_first.
  task automatic load_words(input int n, input int base, input int len_first, input int len_rest);
    int pk = 0;
    int m_len = len_first;
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      logic          lst;
      d = DW'(base + i);
      fifo_q.push_back(d);
      if (m_beat == 0) m_len = (pk == 0) ? len_first : len_rest;
      lst = (m_beat == m_len - 1);
      exp_q.push_back({lst, d});
      m_beat = lst ? 0 : m_beat + 1;
      if (lst) pk++;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic cycle_step();
    logic rd;
    logic done_next;
    logic [DW:0] e;
    @(negedge clk);
    case (tr_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ~m_axis_tready;
      2: m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = (sc_pops < 3);
    endcase
    if (chg_at >= 0 && sc_pops == chg_at) pkt_len = chg_len;
    #1;
    check("pkt_done", pkt_done, exp_done);
    check("pkt_count", pkt_count, mdl_cnt);
    if (pkt_done) done_seen++;
    if (prev_stall) begin
      check("stall_tvalid", m_axis_tvalid, 1'b1);
      check("stall_tdata", m_axis_tdata, prev_data);
    end
    if (m_axis_tvalid && first_v < 0) first_v = sc_cycle;
    done_next = 1'b0;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("tdata", m_axis_tdata, e[DW-1:0]);
        check("tlast", m_axis_tlast, e[DW]);
        done_next = e[DW];
      end
      sc_pops++;
      if (first_pop < 0) first_pop = sc_cycle;
      last_pop = sc_cycle;
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    exp_done = done_next;
    if (done_next) mdl_cnt++;
    if (rd) begin
      if (fifo_q.size() == 0) check("fifo_underflow", 1, 0);
      else fifo_dout = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
    sc_cycle++;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) cycle_step();
  endtask

  task automatic run_drain(input string tag, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      cycle_step();
      n++;
    end
    check(tag, exp_q.size(), 0);
    run_steps(2);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_beat = 0; mdl_cnt = 0; exp_done = 1'b0; prev_stall = 1'b0;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_pkt_done", pkt_done, 1'b0);
    check("rst_pkt_count", pkt_count, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
  endtask

  initial begin
    int cnt0;
    rst = 1'b1; enable = 1'b0; pkt_len = LW'(5); fifo_dout = '0;
    fifo_empty = 1'b1; m_axis_tready = 1'b0;
    apply_reset();

    // Back-to-back packets of 5 at full rate.
    run_steps(2);
    load_words(10, 2, 5, 5);
    enable = 1'b1;
    scen_start();
    tr_mode = 0;
    run_drain("s1_drain", 100);
    check("s1_first_tvalid", first_v, 2);
    check("s1_throughput", last_pop - first_pop, 9);
    check("s1_pkt_count", pkt_count, 2);
    check("s1_idle", busy, 1'b0);

    // Same data under alternating back-pressure.
    scen_start();
    tr_mode = 1;
    load_words(10, 2, 5, 5);
    run_drain("s2_drain", 200);
    check("s2_pkt_count", pkt_count, 4);
    check("s2_beats", sc_pops, 10);

    // Single-beat packets with random back-pressure.
    pkt_len = LW'(1);
    tr_mode = 0;
    run_steps(2);
    scen_start();
    tr_mode = 2;
    load_words(3, 100, 1, 1);
    run_drain("s3_drain", 100);
    check("s3_done_pulses", done_seen, 3);
    check("s3_pkt_count", pkt_count, 7);

    // Length changes mid-packet; takes effect on the following packet.
    pkt_len = LW'(5);
    tr_mode = 0;
    run_steps(2);
    scen_start();
    chg_at = 2; chg_len = LW'(3);
    load_words(8, 20, 5, 3);
    run_drain("s4_drain", 100);
    chg_at = -1;
    check("s4_pkt_count", pkt_count, 9);

    // Reset in the middle of a stalled packet, then a fresh packet.
    pkt_len = LW'(5);
    run_steps(2);
    scen_start();
    tr_mode = 3;
    load_words(5, 40, 5, 5);
    run_steps(8);
    check("s5_pre_rst_pops", sc_pops, 3);
    check("s5_pre_rst_valid", m_axis_tvalid, 1'b1);
    apply_reset();
    tr_mode = 0;
    run_steps(2);
    scen_start();
    load_words(5, 60, 5, 5);
    run_drain("s5_drain", 100);
    check("s5_pkt_count", pkt_count, 1);

    // Partial trailing packet: held and closed by timeout only when the feature is built.
    pkt_len = LW'(4);
    run_steps(2);
    cnt0 = mdl_cnt;
    scen_start();
    load_words(6, 80, 4, 4);
`ifdef FIFO_AXIS_TIMEOUT_EN
    exp_q[$] = {1'b1, exp_q[$][DW-1:0]};
    m_beat = 0;
    run_drain("s6_drain", 200);
    check("s6_pkt_count", pkt_count, cnt0 + 2);
    check("s6_busy", busy, 1'b0);
`else
    run_drain("s6_drain", 200);
    run_steps(TO + 4);
    check("s6_pkt_count", pkt_count, cnt0 + 1);
    check("s6_busy", busy, 1'b1);
`endif
    check("s6_beats", sc_pops, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
